// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scans an NROWS x NCOLS key matrix, debounces one key at a time and
//   presents each debounced press as a key event with a valid/ack handshake.
//
//   Ports
//     clk        : single clock, rising edge
//     reset      : synchronous, active-high
//     rows       : asynchronous row sense lines, active-high
//     cols       : one-hot column drive
//     key_code   : key index, row*NCOLS+col
//     key_valid  : key event pending
//     key_ack    : consumer acknowledge of the pending event
//     key_held   : a debounced key is currently down
//     overrun    : one-cycle pulse when an event is dropped
//
//   Build option
//     KEYPAD_REPEAT_EN : when defined, a held key produces an extra event
//                        every REPEAT_CYCLES cycles.
module keypad_scan_ctrl #(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 500000,
  localparam int KW = (NROWS * NCOLS > 1) ? $clog2(NROWS * NCOLS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NROWS-1:0] rows,
  output logic [NCOLS-1:0] cols,
  output logic [KW-1:0]    key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             key_held,
  output logic             overrun
);

  localparam int RW    = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int CW    = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int MAX_A = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int MAXC  = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    COL_LAST  = CW'(NCOLS - 1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t             state_q, state_d;
  logic [NROWS-1:0]   sync1_q, srows_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]      col_q, col_d, col_next;
  logic [RW-1:0]      row_q, row_d, low_row;
  logic [KW-1:0]      code_q, code_d, key_idx;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               key_bit;
  logic               ev;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_q, rep_d;
`endif

  // The column register is not advanced outside SCAN, so it doubles as the
  // captured column of the key being debounced.
  assign col_next = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
  assign key_bit  = srows_q[row_q];
  assign key_idx  = KW'(row_q) * KW'(NCOLS) + KW'(col_q);

  always_comb begin
    low_row = '0;
    for (int i = NROWS - 1; i >= 0; i--) begin
      if (srows_q[i]) low_row = RW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NCOLS; i++) cols[i] = (col_q == CW'(i));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    ev      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (|srows_q) begin
          row_d   = low_row;
          cnt_d   = '0;
          state_d = PRESS_DB;
        end else if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          col_d = col_next;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESS_DB: begin
        if (!key_bit) begin
          state_d = SCAN;
          cnt_d   = '0;
          col_d   = col_next;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          ev      = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!key_bit) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        // Repeat count is kept (paused) across a release glitch.
        else if (rep_q == REP_LAST) begin
          rep_d = '0;
          ev    = 1'b1;
        end else begin
          rep_d = rep_q + CNT_W'(1);
        end
`endif
      end
      RELEASE_DB: begin
        if (key_bit) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = SCAN;
          cnt_d   = '0;
          col_d   = col_next;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // A new event while one is pending is dropped unless the pending one is
  // being acknowledged in the same cycle, in which case the new one replaces it.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (ev) begin
      if (valid_q && !key_ack) begin
        ovr_d = 1'b1;
      end else begin
        code_d  = key_idx;
        valid_d = 1'b1;
      end
    end else if (valid_q && key_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      sync1_q <= '0;
      srows_q <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= rows;
      srows_q <= sync1_q;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign overrun   = ovr_q;
  assign key_held  = (state_q == HELD) || (state_q == RELEASE_DB);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl with a 4x4 key-matrix model.
// Expected key events are queued by the stimulus; a monitor pops and
// compares them whenever key_valid presents a new event, and acknowledges.
module tb_keypad_scan_ctrl;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RP = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NR-1:0] rows;
  logic [NC-1:0] cols;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          key_ack = 1'b0;
  logic          key_held;
  logic          overrun;

  logic [15:0]   pressed = '0;
  logic          force_en = 1'b0;
  logic [NR-1:0] force_rows = '0;
  logic [NR-1:0] rows_mat;

  int            n_cmp = 0;
  int            n_fail = 0;
  int            ev_seen = 0;
  int            ovr_seen = 0;
  int            ev_exp = 0;
  bit            auto_ack = 1'b1;
  bit            armed = 1'b1;
  int            exp_q[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .NROWS(NR), .NCOLS(NC), .SCAN_DIV(SD),
    .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_held(key_held), .overrun(overrun)
  );

  // Key matrix: a pressed key connects its column drive to its row line.
  always_comb begin
    rows_mat = '0;
    for (int k = 0; k < 16; k++) begin
      if (pressed[k] && cols[k % NC]) rows_mat[k / NC] = 1'b1;
    end
    rows = force_en ? force_rows : rows_mat;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_event(input int code);
    exp_q.push_back(code);
    ev_exp++;
  endtask

  task automatic wait_held(input logic val, input int budget, input string nm);
    int t;
    t = 0;
    while (key_held !== val && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(nm, key_held, val);
  endtask

  task automatic wait_cols(input logic [NC-1:0] v);
    int t;
    t = 0;
    while (cols === v && t < 40) begin @(negedge clk); t++; end
    while (cols !== v && t < 80) begin @(negedge clk); t++; end
    chk("wait_cols", cols, v);
  endtask

  task automatic press_key(input int k, input int hold, input bit counts);
    if (counts) expect_event(k);
    pressed[k] = 1'b1;
    wait_held(1'b1, 80, "press_held");
    cyc(hold);
    pressed[k] = 1'b0;
    wait_held(1'b0, 40, "release_done");
  endtask

  // Monitor: compare each newly presented event, then acknowledge it.
  initial begin : monitor
    int e;
    forever begin
      @(negedge clk);
      if (reset) begin
        key_ack = 1'b0;
        armed   = 1'b1;
      end else begin
        if (overrun) ovr_seen++;
        if (key_ack) begin
          key_ack = 1'b0;
          armed   = 1'b1;
          chk("ack_clears_valid", key_valid, 1'b0);
        end else if (key_valid && armed) begin
          armed = 1'b0;
          ev_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got code %0d expected no event", key_code);
          end else begin
            e = exp_q.pop_front();
            chk("event_code", key_code, e);
          end
          if (auto_ack) key_ack = 1'b1;
        end else if (key_valid && auto_ack) begin
          key_ack = 1'b1;
        end else if (!key_valid) begin
          armed = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    int k, o0, e0;
    logic [NC-1:0] expc;

    // Reset state
    cyc(3);
    chk("rst_cols", cols, 4'b0001);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_code", key_code, 0);
    reset = 1'b0;

    // Idle scan: each column held SD cycles, wrapping to column 0
    for (int i = 0; i < 40; i++) begin
      expc = NC'(1) << ((i / SD) % NC);
      chk("scan_cols", cols, expc);
      @(negedge clk);
    end
    chk("idle_valid", key_valid, 1'b0);

    // Static row 0 asserted while column 2 is driven -> key 2
    wait_cols(4'b0100);
    expect_event(2);
    force_rows = 4'b0001;
    force_en   = 1'b1;
    wait_held(1'b1, 40, "k2_held");
    chk("k2_cols_frozen", cols, 4'b0100);
    cyc(4);
    chk("k2_held_still", key_held, 1'b1);
    force_en = 1'b0;
    wait_held(1'b0, 40, "k2_release");

    // Bounce: 3-cycle pulse on row 1 during column 0 -> no event
    e0 = ev_seen;
    wait_cols(4'b0001);
    force_rows = 4'b0010;
    force_en   = 1'b1;
    cyc(3);
    force_en = 1'b0;
    cyc(20);
    chk("bounce_no_event", ev_seen, e0);
    chk("bounce_held", key_held, 1'b0);
    chk("bounce_valid", key_valid, 1'b0);

    // Overrun: key 5 unacknowledged, then key 9 is dropped
    auto_ack = 1'b0;
    o0 = ovr_seen;
    press_key(5, 6, 1'b1);
    press_key(9, 6, 1'b0);
    chk("ovr_pulses", ovr_seen - o0, 1);
    chk("ovr_code_kept", key_code, 5);
    chk("ovr_valid_kept", key_valid, 1'b1);
    auto_ack = 1'b1;
    cyc(4);
    chk("ovr_acked", key_valid, 1'b0);

    // Release glitch of 3 low cycles -> still one event
    e0 = ev_seen;
    expect_event(11);
    pressed[11] = 1'b1;
    wait_held(1'b1, 80, "glitch_held");
    cyc(4);
    pressed[11] = 1'b0;
    cyc(3);
    pressed[11] = 1'b1;
    cyc(6);
    chk("glitch_still_held", key_held, 1'b1);
    pressed[11] = 1'b0;
    wait_held(1'b0, 40, "glitch_release");
    cyc(2);
    chk("glitch_one_event", ev_seen - e0, 1);

    // Two keys in one column: lowest row wins
    expect_event(1);
    pressed[13] = 1'b1;
    pressed[1]  = 1'b1;
    wait_held(1'b1, 80, "lowrow_held");
    cyc(5);
    pressed[13] = 1'b0;
    pressed[1]  = 1'b0;
    wait_held(1'b0, 40, "lowrow_release");

    // No rollover: other keys pressed while key 6 is held are ignored
    e0 = ev_seen;
    expect_event(6);
    pressed[6] = 1'b1;
    wait_held(1'b1, 80, "roll_held");
    pressed[4]  = 1'b1;
    pressed[14] = 1'b1;
    cyc(6);
    chk("roll_cols_frozen", cols, 4'b0100);
    pressed[4]  = 1'b0;
    pressed[14] = 1'b0;
    cyc(2);
    pressed[6] = 1'b0;
    wait_held(1'b0, 40, "roll_release");
    cyc(2);
    chk("roll_one_event", ev_seen - e0, 1);

    // Auto-repeat: 70 held cycles past debounce
    e0 = ev_seen;
    expect_event(7);
`ifdef KEYPAD_REPEAT_EN
    for (int i = 0; i < 3; i++) expect_event(7);
`endif
    press_key(7, 70, 1'b0);
    cyc(2);
`ifdef KEYPAD_REPEAT_EN
    chk("repeat_events", ev_seen - e0, 4);
`else
    chk("repeat_events", ev_seen - e0, 1);
`endif

    // Randomized presses, with short sub-debounce taps between them
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 15);
      press_key(k, $urandom_range(3, 12), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 15);
        pressed[k] = 1'b1;
        cyc($urandom_range(1, 2));
        pressed[k] = 1'b0;
      end
      cyc($urandom_range(0, 6));
    end
    cyc(4);

    // Reset mid-press-debounce with an event pending
    auto_ack = 1'b0;
    press_key(3, 5, 1'b1);
    cyc(2);
    chk("pend_valid", key_valid, 1'b1);
    force_rows = 4'b0001;
    force_en   = 1'b1;
    cyc(5);
    chk("pdb_not_held", key_held, 1'b0);
    reset = 1'b1;
    force_en = 1'b0;
    cyc(1);
    chk("mid_rst_cols", cols, 4'b0001);
    chk("mid_rst_valid", key_valid, 1'b0);
    chk("mid_rst_held", key_held, 1'b0);
    chk("mid_rst_code", key_code, 0);
    cyc(1);
    reset = 1'b0;
    auto_ack = 1'b1;
    e0 = ev_seen;
    cyc(30);
    chk("post_rst_no_event", ev_seen - e0, 0);
    chk("post_rst_valid", key_valid, 1'b0);

    // Final accounting
    chk("events_total", ev_seen, ev_exp);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
